serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop, LSB first.
//   state | meaning
//   IDLE  | waiting for start, previous result held
//   SHIFT | one bit processed per edge, WIDTH edges
//   DONE  | one-cycle done pulse, start ignored
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             bff;
  logic             x;
  logic             y;
  logic             d;
  logic             bout;
  logic             last;

  assign x       = sa[0];
  assign y       = sb[0];
  assign d       = x ^ y ^ bff;
  assign bout    = (~x & y) | (~(x ^ y) & bff);
  assign res_nxt = {d, res[WIDTH-1:1]};
  assign last    = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end

  // Datapath; the result registers move only on the SHIFT->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            res <= '0;
            bff <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          bff <= bout;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.diff   <= res_nxt;
            bus.borrow <= bout;
            bus.zero   <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH 8, 4 and 16.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_subtractor_if #(.WIDTH(8))  i8  ();
  serial_subtractor_if #(.WIDTH(4))  i4  ();
  serial_subtractor_if #(.WIDTH(16)) i16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  serial_subtractor #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(i4));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the WIDTH=8 unit idle; returns at a negedge, idle again.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input logic ez);
    int nb;
    i8.start = 1'b1; i8.a = a; i8.b = b;
    @(negedge clk);
    i8.start = 1'b0; i8.a = 8'hA5; i8.b = 8'h5A;
    nb = 0;
    for (int i = 0; i < 20 && !i8.done; i++) begin
      if (i8.busy) nb++;
      @(negedge clk);
    end
    check({tag, "_done"},   i8.done, 1'b1);
    check({tag, "_busyn"},  nb, 8);
    check({tag, "_diff"},   i8.diff, ed);
    check({tag, "_borrow"}, i8.borrow, eb);
    check({tag, "_zero"},   i8.zero, ez);
    @(negedge clk);
    check({tag, "_pulse"},  i8.done, 1'b0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b};
    i4.start = 1'b1; i4.a = a; i4.b = b;
    @(negedge clk);
    i4.start = 1'b0;
    for (int i = 0; i < 10 && !i4.done; i++) @(negedge clk);
    check("sw4_done", i4.done, 1'b1);
    check("sw4_res", {i4.zero, i4.borrow, i4.diff}, {(r[3:0] == 4'h0), r});
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b};
    i16.start = 1'b1; i16.a = a; i16.b = b;
    @(negedge clk);
    i16.start = 1'b0;
    for (int i = 0; i < 25 && !i16.done; i++) @(negedge clk);
    check("sw16_done", i16.done, 1'b1);
    check("sw16_res", {i16.zero, i16.borrow, i16.diff}, {(r[15:0] == 16'h0), r});
    @(negedge clk);
  endtask

  initial begin
    int rise[3];
    int nr;
    int nd;
    logic pb;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp = 0; n_err = 0;
    i8.start = 0;  i8.a = 0;  i8.b = 0;
    i4.start = 0;  i4.a = 0;  i4.b = 0;
    i16.start = 0; i16.a = 0; i16.b = 0;
    rst = 1'b1;
    #2;
    check("rst_outs", {i8.busy, i8.done, i8.borrow, i8.zero, i8.diff}, 12'h000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    op8("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    op8("under1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op8("under2", 8'h10, 8'hFF, 8'h11, 1'b1, 1'b0);
    op8("equal", 8'h80, 8'h80, 8'h00, 1'b0, 1'b1);
    op8("ffm0", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

    // start pulses at E3, E5 and in the DONE cycle must be ignored; diff holds 0xFF until E8
    i8.start = 1'b1; i8.a = 8'h5A; i8.b = 8'h3C;
    nd = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i8.done) nd++;
      if (i == 7) check("ign_hold", i8.diff, 8'hFF);
      if (i == 9) check("ign_diff", i8.diff, 8'h1E);
      if (i == 12) check("ign_nobusy", i8.busy, 1'b0);
      i8.start = (i == 3 || i == 5 || i == 9);
      i8.a = 8'hFF; i8.b = 8'h00;
    end
    check("ign_ndone", nd, 1);
    check("ign_final", i8.diff, 8'h1E);

    // async reset mid-operation
    i8.start = 1'b1; i8.a = 8'h00; i8.b = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i8.start = 1'b0;
    end
    check("rst_busy_pre", i8.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid", {i8.busy, i8.done, i8.borrow, i8.zero, i8.diff}, 12'h000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i8.done) nd++;
    end
    check("rst_nodone", nd, 0);
    op8("post_rst", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // back-to-back: accepts every WIDTH+2 cycles
    i8.start = 1'b1; i8.a = 8'h5A; i8.b = 8'h3C;
    nr = 0; pb = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (i8.busy && !pb) begin
        if (nr < 3) rise[nr] = c;
        nr++;
      end
      pb = i8.busy;
    end
    i8.start = 1'b0;
    check("b2b_count", nr, 3);
    check("b2b_first", rise[0], 1);
    check("b2b_gap1", rise[1] - rise[0], 10);
    check("b2b_gap2", rise[2] - rise[1], 10);
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("b2b_diff", i8.diff, 8'h1E);

    op4(4'h0, 4'hF);
    op4(4'h7, 4'h7);
    op16(16'h0000, 16'h0001);
    op16(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      op4(ra[3:0], rb[3:0]);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      op16(ra[15:0], rb[15:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
